// File: rtl/id_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package id_pkg;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_e;
endpackage

// File: rtl/id_scoreboard.sv
// Per-register pending-write counters with net inc/dec update, busy/saturated
// vectors, total in-flight count and a sticky under/overflow error flag.
module id_scoreboard
  import id_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_inc,
  input  reg_idx_t            i_inc_rd,
  input  logic                i_wr,
  input  reg_idx_t            i_wr_rd,
  input  logic                i_kill,
  input  reg_idx_t            i_kill_rd,
  output logic [NUM_REGS-1:0] o_busy,
  output logic [NUM_REGS-1:0] o_sat,
  output logic [2:0]          o_inflight,
  output logic                o_err
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] pend_q [NUM_REGS];
  logic [CNT_W-1:0] pend_d [NUM_REGS];
  logic [2:0]       infl_q, infl_d;
  logic             err_q, err_d;

  always_comb begin
    int v;
    int delta;
    v     = 0;
    delta = 0;
    err_d = err_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = '0;
      if (r != 0) begin
        v = int'(pend_q[r])
          + 32'(i_inc  && (i_inc_rd  == reg_idx_t'(r)))
          - 32'(i_wr   && (i_wr_rd   == reg_idx_t'(r)))
          - 32'(i_kill && (i_kill_rd == reg_idx_t'(r)));
        // Both directions saturate; either event latches the error flag.
        if (v < 0) begin
          v     = 0;
          err_d = 1'b1;
        end else if (v > CNT_MAX) begin
          v     = CNT_MAX;
          err_d = 1'b1;
        end
        pend_d[r] = CNT_W'(v);
        delta     = delta + v - int'(pend_q[r]);
      end
    end
    v = int'(infl_q) + delta;
    if (v < 0) v = 0;
    if (v > 7) v = 7;
    infl_d = 3'(v);
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      o_busy[r] = (r != 0) && (pend_q[r] != '0);
      o_sat[r]  = (r != 0) && (pend_q[r] == CNT_W'(CNT_MAX));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
      infl_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
      infl_q <= infl_d;
      err_q  <= err_d;
    end
  end

  assign o_inflight = infl_q;
  assign o_err      = err_q;

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller: RAW/in-flight stall decisions and post-flush
// bubble sequencing around the register write scoreboard.
module id_hazard_ctrl
  import id_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int CNT_W         = 2,
  parameter int MAX_INFLIGHT  = 4,
  parameter int FLUSH_BUBBLES = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  reg_idx_t            i_rs1,
  input  reg_idx_t            i_rs2,
  input  logic                i_rs1_used,
  input  logic                i_rs2_used,
  input  reg_idx_t            i_rd,
  input  logic                i_rd_wr,
  input  logic                i_wrSig,
  input  reg_idx_t            i_wrReg,
  input  logic                i_kill,
  input  reg_idx_t            i_kill_rd,
  input  logic                i_flush,
  output logic                o_issue,
  output logic                o_stall,
  output logic                o_bubble,
  output logic [NUM_REGS-1:0] o_busy,
  output logic [2:0]          o_inflight,
  output logic                o_err
);

  localparam int BC_W = (FLUSH_BUBBLES > 2) ? $clog2(FLUSH_BUBBLES) : 1;
  localparam logic [BC_W-1:0] BC_LOAD  = BC_W'(FLUSH_BUBBLES - 1);
  localparam logic [2:0]      INFL_MAX = 3'(MAX_INFLIGHT);

  hz_state_e           state_q, state_d;
  logic [BC_W-1:0]     bcnt_q, bcnt_d;
  logic [NUM_REGS-1:0] busy_w, sat_w;
  logic                haz, full;

  id_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_sb (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_inc      (o_issue && i_rd_wr),
    .i_inc_rd   (i_rd),
    .i_wr       (i_wrSig),
    .i_wr_rd    (i_wrReg),
    .i_kill     (i_kill),
    .i_kill_rd  (i_kill_rd),
    .o_busy     (busy_w),
    .o_sat      (sat_w),
    .o_inflight (o_inflight),
    .o_err      (o_err)
  );

  // busy_w[0] is constant 0, so x0 sources never raise a hazard.
  assign haz  = (i_rs1_used && busy_w[i_rs1]) || (i_rs2_used && busy_w[i_rs2]);
  assign full = i_rd_wr && (i_rd != '0) && ((o_inflight == INFL_MAX) || sat_w[i_rd]);

  assign o_busy = i_reset ? '0 : busy_w;

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    o_issue  = 1'b0;
    o_stall  = 1'b0;
    o_bubble = 1'b0;
    case (state_q)
      RUN: begin
        o_issue  = i_valid && !haz && !full && !i_flush;
        o_stall  = i_valid && (haz || full);
        o_bubble = o_stall;
        if (i_flush) begin
          state_d = FLUSH;
          bcnt_d  = BC_LOAD;
        end
      end
      FLUSH: begin
        o_bubble = 1'b1;
        if (i_flush) begin
          bcnt_d = BC_LOAD;
        end else if (bcnt_q == '0) begin
          state_d = RUN;
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (i_reset) begin
      o_issue  = 1'b0;
      o_stall  = 1'b0;
      o_bubble = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench: the driver queues hand-computed expectations per cycle,
// the monitor pops and compares them on the falling edge.
module tb_id_hazard_ctrl;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst, valid, rs1_used, rs2_used, rd_wr, wrsig, kill, flush;
  reg_idx_t    rs1, rs2, rd, wrreg, kill_rd;
  logic        issue, stall, bubble, err;
  logic [31:0] busy;
  logic [2:0]  inflight;

  always #5 clk = ~clk;

  id_hazard_ctrl #(
    .NUM_REGS(32), .CNT_W(2), .MAX_INFLIGHT(4), .FLUSH_BUBBLES(2)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid),
    .i_rs1(rs1), .i_rs2(rs2), .i_rs1_used(rs1_used), .i_rs2_used(rs2_used),
    .i_rd(rd), .i_rd_wr(rd_wr), .i_wrSig(wrsig), .i_wrReg(wrreg),
    .i_kill(kill), .i_kill_rd(kill_rd), .i_flush(flush),
    .o_issue(issue), .o_stall(stall), .o_bubble(bubble),
    .o_busy(busy), .o_inflight(inflight), .o_err(err)
  );

  typedef struct {
    string       nm;
    logic [5:0]  m;
    logic        iss, stl, bub;
    logic [2:0]  inf;
    logic        er;
    logic [31:0] bsy;
  } exp_t;

  localparam logic [5:0] ISS = 6'd1, STL = 6'd2, BUB = 6'd4,
                         INF = 6'd8, ERR = 6'd16, BSY = 6'd32;
  localparam logic [5:0] CTL = ISS | STL | BUB;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   done = 1'b0;

  function automatic exp_t ex(string nm, logic [5:0] m, logic iss, logic stl, logic bub,
                              logic [2:0] inf, logic er, logic [31:0] bsy);
    exp_t e;
    e.nm = nm; e.m = m; e.iss = iss; e.stl = stl; e.bub = bub;
    e.inf = inf; e.er = er; e.bsy = bsy;
    return e;
  endfunction

  task automatic check(string nm, string f, logic [31:0] act, logic [31:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s.%s got=%0h want=%0h", nm, f, act, want);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) check(e.nm, "issue",    32'(issue),    32'(e.iss));
      if (e.m[1]) check(e.nm, "stall",    32'(stall),    32'(e.stl));
      if (e.m[2]) check(e.nm, "bubble",   32'(bubble),   32'(e.bub));
      if (e.m[3]) check(e.nm, "inflight", 32'(inflight), 32'(e.inf));
      if (e.m[4]) check(e.nm, "err",      32'(err),      32'(e.er));
      if (e.m[5]) check(e.nm, "busy",     busy,          e.bsy);
    end
  end

  task automatic clr();
    rst = 0; valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    rd = 0; rd_wr = 0; wrsig = 0; wrreg = 0; kill = 0; kill_rd = 0; flush = 0;
  endtask

  task automatic dec(logic v, reg_idx_t s1, logic u1, reg_idx_t s2, logic u2,
                     reg_idx_t d, logic w);
    valid = v; rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2; rd = d; rd_wr = w;
  endtask

  task automatic wb(reg_idx_t r);
    wrsig = 1; wrreg = r;
  endtask

  task automatic kl(reg_idx_t r);
    kill = 1; kill_rd = r;
  endtask

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic step(exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    @(posedge clk); #1;
    // Reset with a valid writer presented: nothing may issue
    rst = 1; dec(1, 0, 0, 0, 0, 3, 1);
    step(ex("rst", CTL | BSY, 0, 0, 0, 0, 0, 0));
    step(ex("post_rst", CTL | INF | ERR | BSY, 0, 0, 0, 0, 0, 0));

    // RAW on x5
    dec(1, 0, 0, 0, 0, 5, 1);
    step(ex("raw_wr5", CTL | INF, 1, 0, 0, 0, 0, 0));
    dec(1, 5, 1, 0, 0, 0, 0);
    step(ex("raw_stall", CTL | INF | BSY, 0, 1, 1, 1, 0, 32'h20));
    dec(1, 5, 1, 0, 0, 0, 0); wb(5);
    step(ex("raw_nobypass", CTL | INF | BSY, 0, 1, 1, 1, 0, 32'h20));
    dec(1, 5, 1, 0, 0, 0, 0);
    step(ex("raw_release", CTL | INF | BSY, 1, 0, 0, 0, 0, 0));

    // x0 destination and sources, unused source
    dec(1, 0, 0, 0, 0, 0, 1);
    step(ex("x0_rd", CTL | INF, 1, 0, 0, 0, 0, 0));
    dec(1, 0, 1, 0, 0, 0, 0);
    step(ex("x0_rs1", CTL | INF | BSY, 1, 0, 0, 0, 0, 0));
    dec(1, 0, 0, 0, 0, 7, 1);
    step(ex("wr7", CTL | INF, 1, 0, 0, 0, 0, 0));
    dec(1, 0, 0, 7, 0, 0, 0);
    step(ex("rs2_unused", CTL | INF | BSY, 1, 0, 0, 1, 0, 32'h80));
    wb(7);
    step(ex("wb7", CTL | INF, 0, 0, 0, 1, 0, 0));

    // In-flight limit
    dec(1, 0, 0, 0, 0, 1, 1); step(ex("lim_wr1", ISS | INF, 1, 0, 0, 0, 0, 0));
    dec(1, 0, 0, 0, 0, 2, 1); step(ex("lim_wr2", ISS | INF, 1, 0, 0, 1, 0, 0));
    dec(1, 0, 0, 0, 0, 3, 1); step(ex("lim_wr3", ISS | INF, 1, 0, 0, 2, 0, 0));
    dec(1, 0, 0, 0, 0, 4, 1); step(ex("lim_wr4", ISS | INF, 1, 0, 0, 3, 0, 0));
    dec(1, 0, 0, 0, 0, 6, 1);
    step(ex("lim_full", CTL | INF | BSY, 0, 1, 1, 4, 0, 32'h1E));
    dec(1, 0, 0, 0, 0, 6, 1); wb(1);
    step(ex("lim_wb", CTL | INF, 0, 1, 1, 4, 0, 0));
    dec(1, 0, 0, 0, 0, 6, 1);
    step(ex("lim_release", CTL | INF | BSY, 1, 0, 0, 3, 0, 32'h1C));
    wb(2); kl(3);
    step(ex("drain_a", INF | BSY | ERR, 0, 0, 0, 4, 0, 32'h5C));
    wb(4); kl(6);
    step(ex("drain_b", INF | BSY | ERR, 0, 0, 0, 2, 0, 32'h50));

    // Per-register saturation on x8
    dec(1, 0, 0, 0, 0, 8, 1); step(ex("sat_1", ISS | INF | BSY, 1, 0, 0, 0, 0, 0));
    dec(1, 0, 0, 0, 0, 8, 1); step(ex("sat_2", ISS | INF, 1, 0, 0, 1, 0, 0));
    dec(1, 0, 0, 0, 0, 8, 1); step(ex("sat_3", ISS | INF, 1, 0, 0, 2, 0, 0));
    dec(1, 0, 0, 0, 0, 8, 1);
    step(ex("sat_full", CTL | INF | BSY | ERR, 0, 1, 1, 3, 0, 32'h100));
    wb(8); kl(8);
    step(ex("sat_dec2", INF | ERR, 0, 0, 0, 3, 0, 0));
    wb(8);
    step(ex("sat_dec1", INF | BSY, 0, 0, 0, 1, 0, 32'h100));

    // Flush, reload on the first FLUSH cycle, return to RUN
    dec(1, 0, 0, 0, 0, 10, 1); flush = 1;
    step(ex("fl_run", CTL | INF, 0, 0, 0, 0, 0, 0));
    dec(1, 0, 0, 0, 0, 10, 1); flush = 1;
    step(ex("fl_b1_reload", CTL | INF, 0, 0, 1, 0, 0, 0));
    dec(1, 0, 0, 0, 0, 10, 1);
    step(ex("fl_b2", CTL | INF, 0, 0, 1, 0, 0, 0));
    dec(1, 0, 0, 0, 0, 10, 1);
    step(ex("fl_b3", CTL | INF, 0, 0, 1, 0, 0, 0));
    dec(1, 0, 0, 0, 0, 0, 0);
    step(ex("fl_run_again", CTL | INF | BSY, 1, 0, 0, 0, 0, 0));

    // Simultaneous issue + writeback + kill on x9
    dec(1, 0, 0, 0, 0, 9, 1);
    step(ex("sim_pre", ISS | INF, 1, 0, 0, 0, 0, 0));
    dec(1, 0, 0, 0, 0, 9, 1); wb(9); kl(9);
    step(ex("sim_all", CTL | INF | ERR | BSY, 1, 0, 0, 1, 0, 32'h200));
    step(ex("sim_post", INF | ERR | BSY, 0, 0, 0, 0, 0, 0));

    // Underflow, sticky error, then reset clears everything
    wb(12);
    step(ex("uf_cycle", INF | ERR, 0, 0, 0, 0, 0, 0));
    step(ex("uf_err", INF | ERR | BSY, 0, 0, 0, 0, 1, 0));
    step(ex("uf_sticky", ERR, 0, 0, 0, 0, 1, 0));
    dec(1, 0, 0, 0, 0, 13, 1);
    step(ex("pre_rst_wr13", ISS | INF | ERR, 1, 0, 0, 0, 1, 0));
    rst = 1; dec(1, 13, 1, 0, 0, 0, 0);
    step(ex("mid_rst", CTL | BSY, 0, 0, 0, 0, 0, 0));
    step(ex("rst_clear", CTL | INF | ERR | BSY, 0, 0, 0, 0, 0, 0));
    wb(0);
    step(ex("x0_wb", ERR | INF, 0, 0, 0, 0, 0, 0));
    step(ex("x0_wb_noerr", ERR | INF | BSY, 0, 0, 0, 0, 0, 0));

    @(negedge clk); @(negedge clk);
    check("end", "queue_left", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
